program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of 16-bit instruction words written per load.
REQ-002 SHALL have parameter ADDR_W, default 4: write-address width; DEPTH = 2**ADDR_W.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  byte-stream ready; a byte transfers when in_valid & in_ready on a rising edge.
REQ-009 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 wr_addr  output  ADDR_W  instruction-memory write address.
REQ-011 wr_data  output  16  instruction word to write.
REQ-012 cpu_hold  output  1  holds the processor in reset while a load is in progress.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  last load completed; sticky.
REQ-015 err  output  1  checksum mismatch on last load; sticky.

Function
REQ-016 SHALL implement FSM states IDLE, HI, LO, WRITE, CSUM, DONE.
REQ-017 IDLE/DONE: start=1 -> HI, word counter cleared to 0, done and err cleared, checksum accumulator cleared.
REQ-018 HI: in_ready=1; on transfer latch in_data as the word's high byte -> LO.
REQ-019 LO: in_ready=1; on transfer latch in_data as the word's low byte -> WRITE.
REQ-020 WRITE: in_ready=0, wr_en=1 for exactly one cycle, wr_addr=counter, wr_data={high,low}.
REQ-021 WRITE with counter < DEPTH-1 -> counter+1, HI; with counter = DEPTH-1 -> CSUM (macro on) or DONE (macro off).
REQ-022 Minimum throughput: one word per 3 cycles; in_valid low in HI/LO stalls indefinitely with no state change.
REQ-023 In all states other than HI, LO and CSUM, in_ready SHALL be 0 and no byte SHALL be consumed.
REQ-024 busy=1 and cpu_hold=1 in HI, LO, WRITE, CSUM; both 0 in IDLE and DONE.
REQ-025 done=1 in DONE only; remains until the next accepted start or reset.
REQ-026 start while busy SHALL be ignored and SHALL NOT restart the counter.
REQ-027 wr_addr and wr_data SHALL hold their last values when wr_en=0.
REQ-028 Counter wrap: counter SHALL never exceed DEPTH-1; no write beyond DEPTH words per load.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, counter=0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, busy=0, done=0, err=0.
REQ-030 Reset mid-load SHALL abandon the load immediately; words already written are not undone and the partially latched byte is discarded.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN defined: after the last word, state CSUM accepts one extra byte; if it differs from the 8-bit modulo-256 sum of all 2*DEPTH data bytes, err=1; either way -> DONE.
REQ-032 Macro LOADER_CHECKSUM_EN undefined: CSUM state and accumulator absent, WRITE of word DEPTH-1 goes directly to DONE, err tied to 0.

Verification
REQ-033 Reset, start, stream bytes 0x10,0x00,0x12,0x01,... (32 bytes, in_valid held high) -> 16 wr_en pulses, addr 0..15, word 0 = 0x1000, word 1 = 0x1201, done=1, cpu_hold falls the cycle DONE is entered.
REQ-034 Same stream with in_valid toggling every other cycle -> identical writes, no lost or duplicated bytes, in_ready=0 during each WRITE cycle.
REQ-035 start pulsed during word 5 -> ignored; load completes with 16 writes, addresses unbroken.
REQ-036 rst_n low after 7 words -> all outputs at reset values next cycle; new start reloads from address 0.
REQ-037 LOADER_CHECKSUM_EN on, 32 bytes all 0x01 then checksum 0x20 -> err=0, done=1; then reload with checksum 0x21 -> err=1, done=1.
REQ-038 LOADER_CHECKSUM_EN off -> done asserts in the cycle after the 16th wr_en, and no 33rd byte is accepted.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream boot loader that fills instruction memory while holding the CPU
//
// Purpose: after a start request, assembles DEPTH 16-bit instruction words from a
// big-endian byte stream (high byte first) and writes them to instruction memory
// at consecutive addresses, holding the processor in reset until the load ends.
//
// Configuration macro: LOADER_CHECKSUM_EN
//   defined   - one extra byte follows the last word; err is set when it differs
//               from the modulo-256 sum of all 2*DEPTH data bytes.
//   undefined - no checksum byte; the last write goes straight to DONE, err is 0.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   start                 single-cycle load request (ignored while busy)
//   in_valid/in_data      byte stream; a byte moves when in_valid & in_ready
//   in_ready              stream ready (HI, LO and CSUM only)
//   wr_en/wr_addr/wr_data instruction-memory write port, one strobe per word
//   cpu_hold, busy        high while a load is in progress
//   done, err             sticky completion / checksum-mismatch flags

module program_loader #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      HI,
      LO,
      WRITE,
`ifdef LOADER_CHECKSUM_EN
      CSUM,
`endif
      DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] count;
   logic [7:0]        hi_byte;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        sum;
`else
   assign err = 1'b0;
`endif

   // All outputs are registered: each one is updated on the same edge that
   // moves the FSM into the state in which it must hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         count    <= '0;
         hi_byte  <= '0;
         in_ready <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         cpu_hold <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         err      <= 1'b0;
         sum      <= '0;
`endif
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= HI;
                  count    <= '0;
                  done     <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  cpu_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  err      <= 1'b0;
                  sum      <= '0;
`endif
               end
            end
            HI: begin
               if (in_valid && in_ready) begin
                  hi_byte <= in_data;
                  state   <= LO;
`ifdef LOADER_CHECKSUM_EN
                  sum     <= sum + in_data;
`endif
               end
            end
            LO: begin
               // The low byte goes straight into wr_data; the strobe is
               // high for exactly the one cycle spent in WRITE.
               if (in_valid && in_ready) begin
                  wr_en    <= 1'b1;
                  wr_addr  <= count;
                  wr_data  <= {hi_byte, in_data};
                  in_ready <= 1'b0;
                  state    <= WRITE;
`ifdef LOADER_CHECKSUM_EN
                  sum      <= sum + in_data;
`endif
               end
            end
            WRITE: begin
               if (count == LAST) begin
`ifdef LOADER_CHECKSUM_EN
                  state    <= CSUM;
                  in_ready <= 1'b1;
`else
                  state    <= DONE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
`endif
               end else begin
                  count    <= count + 1'b1;
                  in_ready <= 1'b1;
                  state    <= HI;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
               if (in_valid && in_ready) begin
                  err      <= (in_data != sum);
                  in_ready <= 1'b0;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
                  state    <= DONE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader

module tb_program_loader;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              err;

   always #5 clk = ~clk;

   program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   localparam int NBYTES = 2 * DEPTH + 1;
`else
   localparam int NBYTES = 2 * DEPTH;
`endif

   logic [7:0] stream[$];

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [15:0]       d;
      int                c;
   } wr_t;
   wr_t writes[$];

   int   cyc = 0;
   int   done_cyc = -1;
   int   ready_viol = 0;
   int   hold_mism = 0;
   logic done_prev = 1'b0;
   logic hold_prev = 1'b0;
   logic hold_at_done = 1'b1;
   logic hold_before_done = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      wr_t w;
      if (wr_en) begin
         w.a = wr_addr;
         w.d = wr_data;
         w.c = cyc;
         writes.push_back(w);
         if (in_ready) ready_viol++;
      end
      if (busy !== cpu_hold) hold_mism++;
      if (done && !done_prev) begin
         done_cyc         = cyc;
         hold_at_done     = cpu_hold;
         hold_before_done = hold_prev;
      end
      done_prev = done;
      hold_prev = cpu_hold;
   end

   // dmode 0: 0x10,0x00,0x12,0x01,...  1: random  2: all 0x01
   task automatic build(input int dmode, input bit use_csum, input logic [7:0] csum);
      int s;
      stream.delete();
      s = 0;
      for (int i = 0; i < 2 * DEPTH; i++) begin
         logic [7:0] b;
         case (dmode)
            0:       b = (i % 2 == 0) ? 8'(16 + i) : 8'(i / 2);
            1:       b = 8'($urandom_range(0, 255));
            default: b = 8'h01;
         endcase
         stream.push_back(b);
         s = s + int'(b);
      end
`ifdef LOADER_CHECKSUM_EN
      stream.push_back(use_csum ? csum : 8'(s % 256));
`else
      if (use_csum) stream.push_back(csum);
`endif
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_done_clr", 32'(done), 32'd0);
   endtask

   // vmode 0: valid high, 1: toggling, 2: random. Bytes past the stream are
   // offered as 0xEE so any over-consumption is visible in the sent count.
   task automatic drive(input int vmode, input int start_w, input int stop_w,
                        output int sent, output bit timed_out);
      int idx;
      int n;
      int tail;
      bit xfer;
      bit pulsed;
      idx = 0; n = 0; tail = -1; pulsed = 0; timed_out = 0;
      forever begin
         start = 1'b0;
         if (start_w >= 0 && !pulsed && writes.size() >= start_w) begin
            start  = 1'b1;
            pulsed = 1;
         end
         case (vmode)
            0:       in_valid = 1'b1;
            1:       in_valid = n[0];
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         in_data = (idx < stream.size()) ? stream[idx] : 8'hEE;
         xfer = in_valid && in_ready;
         @(posedge clk);
         if (xfer) idx++;
         @(negedge clk);
         #1;
         n++;
         if (stop_w > 0 && writes.size() >= stop_w) break;
         if (done && tail < 0) tail = 3;
         if (tail > 0) tail--;
         if (tail == 0) break;
         if (n > 3000) begin
            timed_out = 1;
            break;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      sent     = idx;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_wr_en"},    32'(wr_en),    32'd0);
      chk({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
      chk({tag, "_wr_data"},  32'(wr_data),  32'd0);
      chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
      chk({tag, "_busy"},     32'(busy),     32'd0);
      chk({tag, "_done"},     32'(done),     32'd0);
      chk({tag, "_err"},      32'(err),      32'd0);
   endtask

   task automatic verify_load(input bit timed_out, input int sent, input bit exp_err,
                              input bit fixed, input logic [15:0] w0, input logic [15:0] w1);
      int nw;
      chk("timeout", 32'(timed_out), 32'd0);
      chk("write_count", 32'(writes.size()), 32'(DEPTH));
      nw = (writes.size() < DEPTH) ? writes.size() : DEPTH;
      for (int i = 0; i < nw; i++) begin
         chk("write_addr", 32'(writes[i].a), 32'(i));
         chk("write_data", 32'(writes[i].d), 32'({stream[2*i], stream[2*i+1]}));
      end
      if (fixed && nw >= 2) begin
         chk("word0", 32'(writes[0].d), 32'(w0));
         chk("word1", 32'(writes[1].d), 32'(w1));
      end
      chk("bytes_consumed", 32'(sent), 32'(NBYTES));
      chk("done", 32'(done), 32'd1);
      chk("err", 32'(err), 32'(exp_err));
      chk("busy_end", 32'(busy), 32'd0);
      chk("hold_end", 32'(cpu_hold), 32'd0);
      chk("ready_in_write", 32'(ready_viol), 32'd0);
      chk("busy_eq_hold", 32'(hold_mism), 32'd0);
      chk("hold_at_done", 32'(hold_at_done), 32'd0);
      chk("hold_before_done", 32'(hold_before_done), 32'd1);
`ifndef LOADER_CHECKSUM_EN
      if (nw > 0) chk("done_latency", 32'(done_cyc), 32'(writes[nw-1].c + 1));
`endif
   endtask

   typedef struct {
      int          vmode;
      int          dmode;
      int          start_w;
      bit          fixed;
      logic [15:0] w0;
      logic [15:0] w1;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int  sent;
      bit  to;

      vecs[0] = '{0, 0, -1, 1'b1, 16'h1000, 16'h1201};
      vecs[1] = '{1, 0, -1, 1'b1, 16'h1000, 16'h1201};
      vecs[2] = '{0, 0,  5, 1'b1, 16'h1000, 16'h1201};
      vecs[3] = '{2, 1, -1, 1'b0, 16'h0000, 16'h0000};
      vecs[4] = '{2, 1,  3, 1'b0, 16'h0000, 16'h0000};
      vecs[5] = '{1, 1, -1, 1'b0, 16'h0000, 16'h0000};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         build(vecs[v].dmode, 1'b0, 8'h00);
         writes.delete();
         ready_viol = 0;
         hold_mism  = 0;
         pulse_start();
         drive(vecs[v].vmode, vecs[v].start_w, 0, sent, to);
         verify_load(to, sent, 1'b0, vecs[v].fixed, vecs[v].w0, vecs[v].w1);
      end

      // Reset in the middle of a load, then a clean reload from address 0.
      build(0, 1'b0, 8'h00);
      writes.delete();
      pulse_start();
      drive(0, -1, 7, sent, to);
      chk("midreset_timeout", 32'(to), 32'd0);
      chk("midreset_writes", 32'(writes.size()), 32'd7);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_state("midreset");
      rst_n = 1'b1;
      writes.delete();
      ready_viol = 0;
      hold_mism  = 0;
      pulse_start();
      drive(0, -1, 0, sent, to);
      verify_load(to, sent, 1'b0, 1'b1, 16'h1000, 16'h1201);

`ifdef LOADER_CHECKSUM_EN
      build(2, 1'b1, 8'h20);
      writes.delete();
      pulse_start();
      drive(0, -1, 0, sent, to);
      verify_load(to, sent, 1'b0, 1'b1, 16'h0101, 16'h0101);

      build(2, 1'b1, 8'h21);
      writes.delete();
      pulse_start();
      drive(0, -1, 0, sent, to);
      verify_load(to, sent, 1'b1, 1'b1, 16'h0101, 16'h0101);

      pulse_start();
      chk("err_cleared_by_start", 32'(err), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
